// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, funct3 codes and the registered decode result.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SRL  = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

    typedef struct packed {
        logic [31:0] data_1;
        logic [31:0] data_2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic        reg_write;
        logic        illegal;
    } dec_out_t;

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SRL);
    endfunction

endpackage

// File: rtl/reg_file.sv
// Integer register file: two combinational write-first read ports, one write port, x0 tied to zero.
module reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wb_en_i,
    input  logic [$clog2(NREGS)-1:0] wb_rd_i,
    input  logic [XLEN-1:0]          wb_data_i,
    input  logic [$clog2(NREGS)-1:0] rs1_i,
    input  logic [$clog2(NREGS)-1:0] rs2_i,
    output logic [XLEN-1:0]          rs1_data_o,
    output logic [XLEN-1:0]          rs2_data_o
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr_hit;

    assign wr_hit = wb_en_i && (wb_rd_i != '0);

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        if (addr == '0)
            return '0;
        else if (wr_hit && (wb_rd_i == addr))
            return wb_data_i;
        else
            return regs_q[addr];
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (wr_hit)
            regs_d[wb_rd_i] = wb_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            regs_q <= '{default: '0};
        else
            regs_q <= regs_d;
    end

    assign rs1_data_o = read_port(rs1_i);
    assign rs2_data_o = read_port(rs2_i);

endmodule

// File: rtl/decode_stage.sv
// Decode stage for OP / OP-IMM: operand fetch, immediate/shamt forming, legality check,
// and a single output register with valid/ready toward execute.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     instr_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] data_1_o,
    output logic [XLEN-1:0] data_2_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [4:0]      rd_o,
    output logic            reg_write_o,
    output logic            illegal_o,
    output logic            valid_o,
    input  logic            ready_i
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        legal;
    logic        accept;
    dec_out_t    dec;
    dec_out_t    out_d, out_q;
    logic        valid_d, valid_q;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];
    assign imm    = {{20{instr_i[31]}}, instr_i[31:20]};

    reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wb_en_i    (wb_en_i),
        .wb_rd_i    (wb_rd_i),
        .wb_data_i  (wb_data_i),
        .rs1_i      (instr_i[19:15]),
        .rs2_i      (instr_i[24:20]),
        .rs1_data_o (rs1_val),
        .rs2_data_o (rs2_val)
    );

    always_comb begin
        dec        = '0;
        legal      = 1'b0;
        dec.data_1 = rs1_val;
        dec.data_2 = rs2_val;
        dec.funct3 = f3;
        dec.rd     = rd;
        case (opcode)
            OPC_OP: begin
                legal      = (f7 == 7'd0) ||
                             ((f7 == FUNCT7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL)));
                dec.funct7 = f7;
                if (is_shift(f3))
                    dec.data_2 = {27'd0, rs2_val[4:0]};
            end
            OPC_OP_IMM: begin
                // instr[30] is an immediate bit for ADDI etc.; only SRAI uses it as a modifier
                if (f3 == F3_SRL)
                    dec.funct7 = {1'b0, instr_i[30], 5'd0};
                if (is_shift(f3))
                    dec.data_2 = {27'd0, instr_i[24:20]};
                else
                    dec.data_2 = imm;
                if (f3 == F3_SLL)
                    legal = (f7 == 7'd0);
                else if (f3 == F3_SRL)
                    legal = (f7 == 7'd0) || (f7 == FUNCT7_ALT);
                else
                    legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        dec.illegal   = !legal;
        dec.reg_write = legal && (rd != 5'd0);
    end

    assign instr_ready_o = !valid_q || ready_i;
    assign accept        = instr_valid_i && instr_ready_o;

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (accept && !flush_i) begin
            out_d   = dec;
            valid_d = 1'b1;
        end else if (flush_i || ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign data_1_o    = out_q.data_1;
    assign data_2_o    = out_q.data_2;
    assign funct3_o    = out_q.funct3;
    assign funct7_o    = out_q.funct7;
    assign rd_o        = out_q.rd;
    assign reg_write_o = out_q.reg_write;
    assign illegal_o   = out_q.illegal;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expected outputs.
module tb_decode_stage;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic        wb_en_i = 1'b0;
    logic [4:0]  wb_rd_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] data_1_o, data_2_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [4:0]  rd_o;
    logic        reg_write_o, illegal_o, valid_o;
    logic        ready_i = 1'b1;

    int nvec = 0;
    int nfail = 0;

    logic [81:0] obs;
    logic [81:0] exp_v;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .wb_en_i       (wb_en_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .flush_i       (flush_i),
        .data_1_o      (data_1_o),
        .data_2_o      (data_2_o),
        .funct3_o      (funct3_o),
        .funct7_o      (funct7_o),
        .rd_o          (rd_o),
        .reg_write_o   (reg_write_o),
        .illegal_o     (illegal_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i)
    );

    assign obs = {data_1_o, data_2_o, funct3_o, funct7_o, rd_o, reg_write_o, illegal_o, valid_o};

    function automatic logic [81:0] ev(input logic [31:0] d1, input logic [31:0] d2,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [4:0] rd, input logic rw,
                                       input logic ill, input logic v);
        return {d1, d2, f3, f7, rd, rw, ill, v};
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        nvec++;
        if (obs !== 82'd0) begin
            nfail++;
            $display("FAIL reset_outputs: got %h want %h", obs, 82'd0);
        end
        nvec++;
        if (instr_ready_o !== 1'b1) begin
            nfail++;
            $display("FAIL reset_ready: got %b want 1", instr_ready_o);
        end
    endtask

    task automatic test_addi();
        instr_i = 32'hFFB00093; instr_valid_i = 1'b1; ready_i = 1'b1;
        step();
        exp_v = ev(32'd0, 32'hFFFFFFFB, 3'b000, 7'd0, 5'd1, 1'b1, 1'b0, 1'b1);
        nvec++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL addi_neg: got %h want %h", obs, exp_v);
        end
        // ADDI with imm bit 10 set (instr[30]=1) must not look like a subtract
        instr_i = i_type(12'h400, 5'd0, 3'b000, 5'd8, OPIMM);
        step();
        exp_v = ev(32'd0, 32'h400, 3'b000, 7'd0, 5'd8, 1'b1, 1'b0, 1'b1);
        nvec++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL addi_bit30: got %h want %h", obs, exp_v);
        end
        instr_valid_i = 1'b0;
        step();
        nvec++;
        if (valid_o !== 1'b0) begin
            nfail++;
            $display("FAIL consume_no_accept: got %b want 0", valid_o);
        end
    endtask

    task automatic test_shifts();
        wb_en_i = 1'b1; wb_rd_i = 5'd2; wb_data_i = 32'h80000000;
        step();
        wb_rd_i = 5'd4; wb_data_i = 32'h23;
        step();
        wb_en_i = 1'b0;
        instr_i = 32'h40415193; instr_valid_i = 1'b1;
        step();
        exp_v = ev(32'h80000000, 32'd4, 3'b101, 7'b0100000, 5'd3, 1'b1, 1'b0, 1'b1);
        nvec++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL srai: got %h want %h", obs, exp_v);
        end
        instr_i = r_type(7'd0, 5'd4, 5'd2, 3'b001, 5'd7);
        step();
        exp_v = ev(32'h80000000, 32'd3, 3'b001, 7'd0, 5'd7, 1'b1, 1'b0, 1'b1);
        nvec++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL sll_shamt_mask: got %h want %h", obs, exp_v);
        end
        instr_i = i_type(12'h403, 5'd0, 3'b001, 5'd9, OPIMM);
        step();
        nvec++;
        if ({illegal_o, reg_write_o, valid_o} !== 3'b101) begin
            nfail++;
            $display("FAIL slli_bad_funct7: got %b want 101", {illegal_o, reg_write_o, valid_o});
        end
        instr_valid_i = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        instr_i = 32'hFFB00093; instr_valid_i = 1'b1; ready_i = 1'b1;
        step();
        exp_v = ev(32'd0, 32'hFFFFFFFB, 3'b000, 7'd0, 5'd1, 1'b1, 1'b0, 1'b1);
        ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            instr_i = i_type(12'(k + 1), 5'd0, 3'b000, 5'(k + 10), OPIMM);
            #1;
            nvec++;
            if (instr_ready_o !== 1'b0) begin
                nfail++;
                $display("FAIL stall_ready cycle %0d: got %b want 0", k, instr_ready_o);
            end
            step();
            nvec++;
            if (obs !== exp_v) begin
                nfail++;
                $display("FAIL stall_hold cycle %0d: got %h want %h", k, obs, exp_v);
            end
        end
        ready_i = 1'b1;
        instr_i = i_type(12'd7, 5'd0, 3'b000, 5'd12, OPIMM);
        #1;
        nvec++;
        if (instr_ready_o !== 1'b1) begin
            nfail++;
            $display("FAIL release_ready: got %b want 1", instr_ready_o);
        end
        step();
        exp_v = ev(32'd0, 32'd7, 3'b000, 7'd0, 5'd12, 1'b1, 1'b0, 1'b1);
        nvec++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL release_load: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_bypass();
        wb_en_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h1234;
        instr_i = r_type(7'd0, 5'd5, 5'd5, 3'b000, 5'd6); instr_valid_i = 1'b1;
        step();
        exp_v = ev(32'h1234, 32'h1234, 3'b000, 7'd0, 5'd6, 1'b1, 1'b0, 1'b1);
        nvec++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL bypass_x5: got %h want %h", obs, exp_v);
        end
        wb_rd_i = 5'd0; wb_data_i = 32'hFFFF;
        instr_i = r_type(7'd0, 5'd0, 5'd0, 3'b000, 5'd9);
        step();
        wb_en_i = 1'b0;
        exp_v = ev(32'd0, 32'd0, 3'b000, 7'd0, 5'd9, 1'b1, 1'b0, 1'b1);
        nvec++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL bypass_x0: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_illegal();
        instr_i = i_type(12'd0, 5'd0, 3'b010, 5'd1, 7'b0000011); instr_valid_i = 1'b1;
        step();
        nvec++;
        if ({illegal_o, reg_write_o, valid_o} !== 3'b101) begin
            nfail++;
            $display("FAIL load_illegal: got %b want 101", {illegal_o, reg_write_o, valid_o});
        end
        instr_i = r_type(7'b0100000, 5'd2, 5'd1, 3'b100, 5'd3);
        step();
        nvec++;
        if ({illegal_o, reg_write_o, valid_o} !== 3'b101) begin
            nfail++;
            $display("FAIL op_alt_xor_illegal: got %b want 101", {illegal_o, reg_write_o, valid_o});
        end
        instr_i = r_type(7'b0100000, 5'd5, 5'd5, 3'b000, 5'd10);
        step();
        exp_v = ev(32'h1234, 32'h1234, 3'b000, 7'b0100000, 5'd10, 1'b1, 1'b0, 1'b1);
        nvec++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL sub_legal: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_flush();
        instr_i = 32'hFFB00093; instr_valid_i = 1'b1; ready_i = 1'b1; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        nvec++;
        if (valid_o !== 1'b0) begin
            nfail++;
            $display("FAIL flush_accept: got %b want 0", valid_o);
        end
        step();
        ready_i = 1'b0; instr_valid_i = 1'b0; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        nvec++;
        if (valid_o !== 1'b0) begin
            nfail++;
            $display("FAIL flush_held: got %b want 0", valid_o);
        end
    endtask

    task automatic test_reset_mid();
        instr_i = r_type(7'd0, 5'd5, 5'd5, 3'b000, 5'd6); instr_valid_i = 1'b1; ready_i = 1'b0;
        step();
        step();
        nvec++;
        if (valid_o !== 1'b1) begin
            nfail++;
            $display("FAIL stall_before_reset: got %b want 1", valid_o);
        end
        rst_i = 1'b1; wb_en_i = 1'b1; wb_rd_i = 5'd10; wb_data_i = 32'hDEAD;
        step();
        rst_i = 1'b0; wb_en_i = 1'b0; instr_valid_i = 1'b0;
        nvec++;
        if (obs !== 82'd0) begin
            nfail++;
            $display("FAIL mid_reset_outputs: got %h want %h", obs, 82'd0);
        end
        ready_i = 1'b1; instr_valid_i = 1'b1;
        for (int i = 1; i < 32; i++) begin
            instr_i = r_type(7'd0, 5'(i), 5'(i), 3'b000, 5'd1);
            step();
            nvec++;
            if ({data_1_o, data_2_o} !== 64'd0) begin
                nfail++;
                $display("FAIL regfile_cleared x%0d: got %h want 0", i, {data_1_o, data_2_o});
            end
        end
        instr_valid_i = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_addi();
        test_shifts();
        test_back_to_back();
        test_bypass();
        test_illegal();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
